memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
- Shares the single-port unified RAM between the fetch stage (instruction read) and the memory stage (data load/store).
- The memory stage's result feeds dload into the memory/writeback latch.
- Grants one requester at a time and holds the RAM command stable for a fixed RAM_LATENCY cycles.
- Returns a one-cycle ready strobe with load data; round-robin tie-break prevents fetch starvation under back-to-back data traffic.

Parameters:
RAM_LATENCY, 2, cycles the RAM command is held before read data is valid / write is committed; legal range 1..15
CNT_W, 4, width of the internal latency down-counter; must hold RAM_LATENCY-1

Ports:
clk  input  1  system clock, rising edge
nrst  input  1  asynchronous active-low reset
i_req  input  1  fetch read request; held until i_ready
i_addr  input  32  fetch word address (word_t)
i_ready  output  1  fetch transaction complete this cycle
i_load  output  32  instruction word, valid when i_ready
d_ren  input  1  data read request; held until d_ready
d_wen  input  1  data write request; held until d_ready
d_addr  input  32  data byte address
d_store  input  32  write data
d_strb  input  4  byte write enables
d_ready  output  1  data transaction complete this cycle
d_load  output  32  load data, valid when d_ready
ram_ren  output  1  RAM read command
ram_wen  output  1  RAM write command
ram_addr  output  32  RAM address
ram_store  output  32  RAM write data
ram_strb  output  4  RAM byte enables
ram_load  input  32  RAM read data, valid in final latency cycle

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is asynchronous and active-low.
- States: IDLE, IFETCH, DACCESS. Encoded as arb_state_t.
- Reset values:
  - state=IDLE, cnt=0, last_grant=DATA.
  - Latched addr/store/strb/wen = 0.
  - All outputs 0: ram_ren, ram_wen, ram_addr, ram_store, ram_strb, i_ready, d_ready, i_load, d_load.
- IDLE grant (evaluated each edge):
  - If a data request (d_ren|d_wen) and i_req are both pending: grant the port not equal to last_grant.
  - Otherwise grant whichever is pending.
  - Grant latches address, store, strb and write flag into internal registers, loads cnt=RAM_LATENCY-1, and sets last_grant.
  - d_ren and d_wen both high is treated as a write.
- IFETCH/DACCESS:
  - RAM outputs are driven from the latched registers only. Requester input changes mid-transaction have no effect.
  - In IFETCH, ram_ren=1 and ram_wen=0. In DACCESS, ram_wen=latched write flag and ram_ren=!write flag. ram_store/ram_strb are zero for reads.
  - cnt decrements each cycle.
  - When cnt==0: the granted port's ready=1 (combinational), its load = ram_load pass-through (0 for writes), and the next state is IDLE.
- Latency:
  - Request first seen in IDLE at cycle 0; ready in cycle RAM_LATENCY.
  - Next grant at the edge ending cycle RAM_LATENCY+1, i.e. one IDLE bubble between transactions.
  - Requester must deassert or change its request in the cycle after ready. A request still held in that IDLE cycle is treated as new.
- Outputs in IDLE: i_ready=d_ready=0 and ram_* = 0.
- i_load/d_load: zero whenever the corresponding ready is 0.
- Requester drops its request mid-transaction: the transaction completes, and the ready strobe is still issued.
- nrst asserted mid-transaction: the transaction is aborted immediately, with no ready and no further RAM command.

Decomposition:
- common_types_pkg:
  - arb_state_t enum (IDLE, IFETCH, DACCESS).
  - grant_t enum (INSTR, DATA).
  - Reuse word_t.
- No sub-module; the latency counter is inline.

Test Plan:
- Reset, then i_req=1, i_addr=0x100, RAM_LATENCY=2 -> ram_ren=1, ram_addr=0x100 in cycles 1-2; i_ready=1, i_load=ram_load in cycle 2; IDLE in cycle 3.
- d_wen=1, d_addr=0x204, d_store=0xDEADBEEF, d_strb=0xF -> ram_wen=1 with those values for 2 cycles; d_ready in cycle 2; d_load=0.
- i_req and d_ren asserted together in IDLE after reset (last_grant=DATA) -> instruction served first, then data. Repeat with last_grant=INSTR -> data first.
- Continuous d_ren plus i_req for 6 transactions -> grants alternate D, I, D, I, D, I; no starvation.
- Change d_addr from 0x10 to 0x20 mid-transaction -> ram_addr stays 0x10 until d_ready.
- Pull nrst low during cycle 1 of a read -> all outputs 0 immediately; no i_ready; a fresh request after release behaves like the first scenario.

Source files
------------

// File: rtl/common_types_pkg.sv
// Shared types for the unified-RAM arbiter: word type, FSM encoding, grant id.
package common_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates the single-port unified RAM between instruction fetch and the
// data (load/store) stage. One requester owns the RAM for RAM_LATENCY cycles;
// the command is driven only from values latched at grant time, and a one-cycle
// ready strobe closes each transaction. Round-robin on ties avoids starvation.
module memory_arbiter
  import common_types_pkg::*;
#(
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        nrst,
  // fetch port
  input  logic        i_req,
  input  word_t       i_addr,
  output logic        i_ready,
  output word_t       i_load,
  // data port
  input  logic        d_ren,
  input  logic        d_wen,
  input  word_t       d_addr,
  input  word_t       d_store,
  input  logic [3:0]  d_strb,
  output logic        d_ready,
  output word_t       d_load,
  // RAM port
  output logic        ram_ren,
  output logic        ram_wen,
  output word_t       ram_addr,
  output word_t       ram_store,
  output logic [3:0]  ram_strb,
  input  word_t       ram_load
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RAM_LATENCY - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  grant_t           last_q, last_d;
  word_t            addr_q, addr_d;
  word_t            store_q, store_d;
  logic [3:0]       strb_q, strb_d;
  logic             wen_q, wen_d;

  logic             d_pend;
  logic             grant_instr;
  logic             busy;
  logic             last_cycle;

  assign d_pend = d_ren | d_wen;

  // Next-state: grant in IDLE, count down while a transaction is in flight.
  always_comb begin
    // NOTE: every variable gets a default up front so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    store_d     = store_q;
    strb_d      = strb_q;
    wen_d       = wen_q;
    grant_instr = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_pend) begin
          // On a tie the port that did not win last time goes first.
          grant_instr = i_req && (!d_pend || (last_q == DATA));
          cnt_d       = LAT_M1;
          if (grant_instr) begin
            state_d = IFETCH;
            last_d  = INSTR;
            addr_d  = i_addr;
            store_d = '0;
            strb_d  = '0;
            wen_d   = 1'b0;
          end else begin
            // Read and write both asserted resolves to a write.
            state_d = DACCESS;
            last_d  = DATA;
            addr_d  = d_addr;
            store_d = d_wen ? d_store : '0;
            strb_d  = d_wen ? d_strb : '0;
            wen_d   = d_wen;
          end
        end
      end
      IFETCH, DACCESS: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched command registers; reset aborts any transaction at once.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= DATA;
      addr_q  <= '0;
      store_q <= '0;
      strb_q  <= '0;
      wen_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      strb_q  <= strb_d;
      wen_q   <= wen_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign last_cycle = busy && (cnt_q == '0);

  // RAM command comes only from latched values, so requester churn is invisible.
  assign ram_ren   = (state_q == IFETCH) || ((state_q == DACCESS) && !wen_q);
  assign ram_wen   = (state_q == DACCESS) && wen_q;
  assign ram_addr  = busy ? addr_q : '0;
  assign ram_store = ram_wen ? store_q : '0;
  assign ram_strb  = ram_wen ? strb_q : '0;

  assign i_ready = last_cycle && (state_q == IFETCH);
  assign i_load  = i_ready ? ram_load : '0;
  assign d_ready = last_cycle && (state_q == DACCESS);
  assign d_load  = (d_ready && !wen_q) ? ram_load : '0;

endmodule
